// File: rtl/hilo_div_ctrl.sv
// EX-stage divide controller: issues DIV/DIVU to the multi-cycle divider, stalls until the
// result returns, commits remainder/quotient to HI/LO, drains flushed divides, serves MTHI/MTLO.
module hilo_div_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 63
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_div_req,
  input  logic                ex_div_sign,
  input  logic [DATA_W-1:0]   ex_rs,
  input  logic [DATA_W-1:0]   ex_rt,
  input  logic                flush,
  input  logic                wb_hi_we,
  input  logic                wb_lo_we,
  input  logic [DATA_W-1:0]   wb_wdata,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                stall_o,
  output logic                div_err,
  output logic [DATA_W-1:0]   div_a,
  output logic [DATA_W-1:0]   div_b,
  output logic                div_sign,
  output logic                div_opn_valid,
  output logic                div_res_ready,
  input  logic                div_res_valid,
  input  logic [2*DATA_W-1:0] div_result
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             commit;
  logic             timeout;
  logic             waiting;

  // Operands go straight through; the divider samples them on the issue edge.
  assign div_a    = ex_rs;
  assign div_b    = ex_rt;
  assign div_sign = ex_div_sign;

  assign waiting = (state == BUSY) || (state == DRAIN);

  // Next-state and handshake decode.
  always_comb begin
    state_nxt     = state;
    div_opn_valid = 1'b0;
    div_res_ready = 1'b0;
    stall_o       = 1'b0;
    commit        = 1'b0;
    timeout       = 1'b0;
    case (state)
      IDLE: begin
        div_opn_valid = ex_div_req & ~flush;
        stall_o       = ex_div_req & ~flush;
        if (ex_div_req && !flush) state_nxt = BUSY;
      end
      BUSY: begin
        div_res_ready = 1'b1;
        stall_o       = ~flush;
        if (flush) begin
          state_nxt = div_res_valid ? IDLE : DRAIN;
        end else if (div_res_valid) begin
          commit    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      DRAIN: begin
        div_res_ready = 1'b1;
        stall_o       = ex_div_req;
        if (div_res_valid) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // A divider that never answers must not hang the pipeline.
    if (waiting && (state_nxt == state) && (cnt >= CNT_W'(TIMEOUT_CYC - 1))) begin
      timeout   = 1'b1;
      state_nxt = IDLE;
    end
    if (rst) begin
      div_opn_valid = 1'b0;
      div_res_ready = 1'b0;
      stall_o       = 1'b0;
      commit        = 1'b0;
      timeout       = 1'b0;
    end
  end

  // State, timeout counter and HI/LO; a divider commit overrides a colliding MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_o    <= '0;
      lo_o    <= '0;
      div_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= waiting ? cnt + CNT_W'(1) : '0;
      if (timeout) div_err <= 1'b1;
      if (commit) begin
        hi_o <= div_result[2*DATA_W-1:DATA_W];
        lo_o <= div_result[DATA_W-1:0];
      end else begin
        if (wb_hi_we) hi_o <= wb_wdata;
        if (wb_lo_we) lo_o <= wb_wdata;
      end
    end
  end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Bench for hilo_div_ctrl: 33-cycle divider model, expected HI/LO queued at issue and
// checked by a monitor on every committed result.
module tb_hilo_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_div_req;
  logic        ex_div_sign;
  logic [31:0] ex_rs;
  logic [31:0] ex_rt;
  logic        flush;
  logic        wb_hi_we;
  logic        wb_lo_we;
  logic [31:0] wb_wdata;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_o;
  logic        div_err;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_sign;
  logic        div_opn_valid;
  logic        div_res_ready;
  logic        div_res_valid;
  logic [63:0] div_result;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_hi[$];
  logic [31:0] sb_lo[$];

  hilo_div_ctrl #(.DATA_W(32), .TIMEOUT_CYC(63)) dut (
    .clk(clk), .rst(rst), .ex_div_req(ex_div_req), .ex_div_sign(ex_div_sign),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .wb_hi_we(wb_hi_we),
    .wb_lo_we(wb_lo_we), .wb_wdata(wb_wdata), .hi_o(hi_o), .lo_o(lo_o),
    .stall_o(stall_o), .div_err(div_err), .div_a(div_a), .div_b(div_b),
    .div_sign(div_sign), .div_opn_valid(div_opn_valid), .div_res_ready(div_res_ready),
    .div_res_valid(div_res_valid), .div_result(div_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Divider model: result valid 33 cycles after the issue cycle; mute models a dead divider.
  logic        busy_m;
  int          cnt_m;
  logic        killed;
  logic        mute;
  logic [63:0] res_m;

  function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0] q;
    logic [31:0] r;
    sa = a;
    sb = b;
    if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign div_res_valid = busy_m && (cnt_m >= 33);
  assign div_result    = res_m;

  always @(posedge clk) begin
    if (rst || mute) begin
      busy_m <= 1'b0;
      cnt_m  <= 0;
      killed <= 1'b0;
    end else if (busy_m) begin
      if (div_opn_valid) begin
        checks++;
        errors++;
        $display("FAIL double_issue actual=1 required=0");
      end
      if (flush) killed <= 1'b1;
      if (div_res_valid && div_res_ready) busy_m <= 1'b0;
      else cnt_m <= cnt_m + 1;
    end else if (div_opn_valid) begin
      busy_m <= 1'b1;
      cnt_m  <= 1;
      killed <= 1'b0;
      res_m  <= div_calc(div_a, div_b, div_sign);
    end
  end

  // Monitor: a non-killed result handshake must show the queued HI/LO one edge later.
  logic commit_seen = 1'b0;
  always @(posedge clk)
    commit_seen <= !rst && div_res_valid && div_res_ready && !flush && !killed;

  always @(negedge clk) begin
    if (commit_seen) begin
      if (sb_hi.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit actual=hi%h/lo%h required=none", hi_o, lo_o);
      end else begin
        chk("commit_hi", hi_o, sb_hi.pop_front());
        chk("commit_lo", lo_o, sb_lo.pop_front());
      end
    end
  end

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eh, input logic [31:0] el, input bit collide);
    int n;
    int pulses;
    n = 0;
    pulses = 0;
    sb_hi.push_back(eh);
    sb_lo.push_back(el);
    ex_rs = a;
    ex_rt = b;
    ex_div_sign = s;
    ex_div_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (div_opn_valid) pulses++;
      if (!stall_o) break;
      n++;
      if (collide && div_res_valid) begin
        wb_hi_we = 1'b1;
        wb_wdata = 32'h0000ABCD;
      end
      @(negedge clk);
      wb_hi_we = 1'b0;
    end
    ex_div_req = 1'b0;
    chk("stall_cycles", 32'(n), 32'd34);
    chk("issue_pulses", 32'(pulses), 32'd1);
    if (collide) begin
      wb_lo_we = 1'b1;
      wb_wdata = 32'h00001234;
    end
    @(negedge clk);
    wb_lo_we = 1'b0;
    if (collide) begin
      #1;
      chk("mtlo_after_commit", lo_o, 32'h00001234);
      chk("hi_div_wins", hi_o, 32'h0);
    end
  endtask

  initial begin
    int k;
    rst = 1'b1; ex_div_req = 1'b1; ex_div_sign = 1'b1; ex_rs = 32'd5; ex_rt = 32'd1;
    flush = 1'b0; wb_hi_we = 1'b0; wb_lo_we = 1'b0; wb_wdata = '0; mute = 1'b0;
    @(negedge clk); #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_opn_valid", 32'(div_opn_valid), 32'd0);
    chk("rst_res_ready", 32'(div_res_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ex_div_req = 1'b0;
    #1;
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_err", 32'(div_err), 32'd0);
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_div(32'hFFFFFFFF, 32'd2, 1'b0, 32'd1, 32'h7FFFFFFF, 1'b0);

    // Flush 10 cycles after issue, younger DIV 9/3 waits through the drain.
    ex_div_req = 1'b1; ex_rs = 32'd77; ex_rt = 32'd5; ex_div_sign = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    flush = 1'b0; ex_rs = 32'd9; ex_rt = 32'd3; ex_div_sign = 1'b1;
    sb_hi.push_back(32'd0);
    sb_lo.push_back(32'd3);
    #1;
    chk("drain_stall", 32'(stall_o), 32'd1);
    repeat (30) @(negedge clk);
    #1;
    chk("killed_hi", hi_o, 32'd1);
    chk("killed_lo", lo_o, 32'h7FFFFFFF);
    k = 0;
    while (stall_o && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    chk("drain_done", 32'(stall_o), 32'd0);
    ex_div_req = 1'b0;
    @(negedge clk);

    run_div(32'd50, 32'd5, 1'b0, 32'd0, 32'd10, 1'b1);

    // Dead divider: timeout after 63 BUSY cycles.
    mute = 1'b1;
    ex_div_req = 1'b1; ex_rs = 32'd8; ex_rt = 32'd2; ex_div_sign = 1'b0;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (div_err) break;
      k++;
      @(negedge clk);
    end
    ex_div_req = 1'b0;
    #1;
    chk("timeout_cycles", 32'(k), 32'd64);
    chk("timeout_err", 32'(div_err), 32'd1);
    chk("timeout_stall", 32'(stall_o), 32'd0);
    chk("timeout_ready", 32'(div_res_ready), 32'd0);
    chk("timeout_lo", lo_o, 32'h00001234);
    @(negedge clk);
    mute = 1'b0;

    // Reset in the middle of a divide.
    ex_div_req = 1'b1; ex_rs = 32'd100; ex_rt = 32'd7; ex_div_sign = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    ex_div_req = 1'b0;
    #1;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_ready", 32'(div_res_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_hi", hi_o, 32'h0);
    chk("midrst_lo", lo_o, 32'h0);
    chk("midrst_err", 32'(div_err), 32'd0);
    chk("midrst_stall_after", 32'(stall_o), 32'd0);
    @(negedge clk);
    run_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(sb_hi.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
